// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan code set 2 decoder: tracks E0/F0 prefixes and shift keys, maps make
// codes to ASCII and queues characters in a small FIFO with a valid/ready output.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ps2_received_data,
  input  logic       ps2_received_data_strb,
  input  logic       char_ready,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       shift_active,
  output logic       fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EXT       = 2'd1,
    BREAK     = 2'd2,
    EXT_BREAK = 2'd3
  } state_t;

  state_t         state_r, state_nxt_s;
  logic           shift_l_r, shift_r_r, shift_active_r;
  logic           shift_l_nxt_s, shift_r_nxt_s;
  logic           push_req_s, pop_s, full_s, push_ok_s, overflow_s;
  logic [7:0]     push_char_s;
  logic [8:0]     lookup_s;
  logic [7:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_r, rd_ptr_r;
  logic [AW:0]    count_r;
  logic           fifo_overflow_r;

  // Returns {hit, ascii}; letters are uppercase regardless of shift.
  function automatic logic [8:0] map_code(input logic [7:0] code, input logic shift);
    case (code)
      8'h1C: map_code = {1'b1, 8'h41};  8'h32: map_code = {1'b1, 8'h42};
      8'h21: map_code = {1'b1, 8'h43};  8'h23: map_code = {1'b1, 8'h44};
      8'h24: map_code = {1'b1, 8'h45};  8'h2B: map_code = {1'b1, 8'h46};
      8'h34: map_code = {1'b1, 8'h47};  8'h33: map_code = {1'b1, 8'h48};
      8'h43: map_code = {1'b1, 8'h49};  8'h3B: map_code = {1'b1, 8'h4A};
      8'h42: map_code = {1'b1, 8'h4B};  8'h4B: map_code = {1'b1, 8'h4C};
      8'h3A: map_code = {1'b1, 8'h4D};  8'h31: map_code = {1'b1, 8'h4E};
      8'h44: map_code = {1'b1, 8'h4F};  8'h4D: map_code = {1'b1, 8'h50};
      8'h15: map_code = {1'b1, 8'h51};  8'h2D: map_code = {1'b1, 8'h52};
      8'h1B: map_code = {1'b1, 8'h53};  8'h2C: map_code = {1'b1, 8'h54};
      8'h3C: map_code = {1'b1, 8'h55};  8'h2A: map_code = {1'b1, 8'h56};
      8'h1D: map_code = {1'b1, 8'h57};  8'h22: map_code = {1'b1, 8'h58};
      8'h35: map_code = {1'b1, 8'h59};  8'h1A: map_code = {1'b1, 8'h5A};
      8'h45: map_code = {1'b1, 8'h30};  8'h16: map_code = {1'b1, 8'h31};
      8'h1E: map_code = {1'b1, 8'h32};  8'h26: map_code = {1'b1, 8'h33};
      8'h25: map_code = {1'b1, 8'h34};  8'h2E: map_code = {1'b1, 8'h35};
      8'h36: map_code = {1'b1, 8'h36};  8'h3D: map_code = {1'b1, 8'h37};
      8'h3E: map_code = {1'b1, 8'h38};  8'h46: map_code = {1'b1, 8'h39};
      8'h29: map_code = {1'b1, 8'h20};  8'h5A: map_code = {1'b1, 8'h0D};
      8'h66: map_code = {1'b1, 8'h08};  8'h49: map_code = {1'b1, 8'h2E};
      8'h41: map_code = {1'b1, 8'h2C};
      8'h4A: map_code = shift ? {1'b1, 8'h3F} : {1'b1, 8'h2F};
      default: map_code = 9'h000;
    endcase
  endfunction

  assign lookup_s = map_code(ps2_received_data, shift_active_r);

  // Prefix FSM next state, shift flags and push request.
  always_comb begin
    state_nxt_s   = state_r;
    shift_l_nxt_s = shift_l_r;
    shift_r_nxt_s = shift_r_r;
    push_req_s    = 1'b0;
    push_char_s   = 8'h00;
    if (ps2_received_data_strb) begin
      case (state_r)
        IDLE: begin
          case (ps2_received_data)
            8'hE0: state_nxt_s = EXT;
            8'hF0: state_nxt_s = BREAK;
            8'h12: shift_l_nxt_s = 1'b1;
            8'h59: shift_r_nxt_s = 1'b1;
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nxt_s = IDLE;
            default: begin
              push_req_s  = lookup_s[8];
              push_char_s = lookup_s[7:0];
            end
          endcase
        end
        EXT: begin
          if (ps2_received_data == 8'hF0) begin
            state_nxt_s = EXT_BREAK;
          end else if (ps2_received_data == 8'h5A) begin
            state_nxt_s = IDLE;
            push_req_s  = 1'b1;
            push_char_s = 8'h0D;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        BREAK: begin
          state_nxt_s = IDLE;
          if (ps2_received_data == 8'h12) begin
            shift_l_nxt_s = 1'b0;
          end else if (ps2_received_data == 8'h59) begin
            shift_r_nxt_s = 1'b0;
          end else begin
            shift_l_nxt_s = shift_l_r;
          end
        end
        EXT_BREAK: state_nxt_s = IDLE;
        default:   state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state and shift flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      shift_l_r      <= 1'b0;
      shift_r_r      <= 1'b0;
      shift_active_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      shift_l_r      <= shift_l_nxt_s;
      shift_r_r      <= shift_r_nxt_s;
      shift_active_r <= shift_l_nxt_s | shift_r_nxt_s;
    end
  end

  assign pop_s      = (count_r != {(AW + 1){1'b0}}) && char_ready;
  assign full_s     = (count_r == FULL_CNT);
  assign push_ok_s  = push_req_s && (!full_s || pop_s);
  assign overflow_s = push_req_s && full_s && !pop_s;

  // Character FIFO storage, pointers, occupancy and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 8'h00;
      wr_ptr_r        <= {AW{1'b0}};
      rd_ptr_r        <= {AW{1'b0}};
      count_r         <= {(AW + 1){1'b0}};
      fifo_overflow_r <= 1'b0;
    end else begin
      fifo_overflow_r <= overflow_s;
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_char_s;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign char_data     = mem_r[rd_ptr_r];
  assign char_valid    = (count_r != {(AW + 1){1'b0}});
  assign shift_active  = shift_active_r;
  assign fifo_overflow = fifo_overflow_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed steps plus random byte stream, checked
// every cycle against a prefix-queue / character-queue reference model.
module tb_ps2_scancode_decoder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strb = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] char_data;
  logic       char_valid, shift_active, fifo_overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] prefix[$];
  logic       held_l, held_r, exp_ovf;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] pool [20] = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h1C, 8'h32, 8'h4A, 8'h5A,
    8'h16, 8'h46, 8'h29, 8'h66, 8'h49, 8'h41, 8'h75, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h0E};

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .ps2_received_data      (rx_data),
    .ps2_received_data_strb (rx_strb),
    .char_ready             (ready),
    .char_data              (char_data),
    .char_valid             (char_valid),
    .shift_active           (shift_active),
    .fifo_overflow          (fifo_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ref_map(input logic [7:0] b, input logic shifted);
    for (int i = 0; i < 26; i++) if (letter_codes[i] == b) return {1'b1, 8'(8'h41 + i)};
    for (int i = 0; i < 10; i++) if (digit_codes[i] == b) return {1'b1, 8'(8'h30 + i)};
    case (b)
      8'h29: return {1'b1, 8'h20};
      8'h5A: return {1'b1, 8'h0D};
      8'h66: return {1'b1, 8'h08};
      8'h49: return {1'b1, 8'h2E};
      8'h41: return {1'b1, 8'h2C};
      8'h4A: return {1'b1, shifted ? 8'h3F : 8'h2F};
      default: return 9'h000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    prefix.delete();
    held_l  = 1'b0;
    held_r  = 1'b0;
    exp_ovf = 1'b0;
  endtask

  // Reference behaviour for one clock edge, from pre-edge inputs and state.
  task automatic model_edge(input logic s, input logic [7:0] b, input logic r);
    logic       pop, req;
    logic [7:0] ch;
    logic [8:0] m;
    pop = (mq.size() != 0) && r;
    req = 1'b0;
    ch  = 8'h00;
    if (s) begin
      if (prefix.size() == 0) begin
        if (b == 8'hE0 || b == 8'hF0) prefix.push_back(b);
        else if (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) req = 1'b0;
        else if (b == 8'h12) held_l = 1'b1;
        else if (b == 8'h59) held_r = 1'b1;
        else begin
          m   = ref_map(b, held_l | held_r);
          req = m[8];
          ch  = m[7:0];
        end
      end else if (prefix.size() == 1 && prefix[0] == 8'hE0 && b == 8'hF0) begin
        prefix.push_back(b);
      end else begin
        if (prefix.size() == 1 && prefix[0] == 8'hE0 && b == 8'h5A) begin
          req = 1'b1;
          ch  = 8'h0D;
        end
        if (prefix.size() == 1 && prefix[0] == 8'hF0) begin
          if (b == 8'h12) held_l = 1'b0;
          if (b == 8'h59) held_r = 1'b0;
        end
        prefix.delete();
      end
    end
    exp_ovf = req && (mq.size() == DEPTH) && !pop;
    if (pop) void'(mq.pop_front());
    if (req && !exp_ovf) mq.push_back(ch);
  endtask

  task automatic check_all();
    chk("valid", {7'd0, char_valid}, {7'd0, mq.size() != 0});
    if (mq.size() != 0) chk("data", char_data, mq[0]);
    chk("shift", {7'd0, shift_active}, {7'd0, held_l | held_r});
    chk("overflow", {7'd0, fifo_overflow}, {7'd0, exp_ovf});
  endtask

  task automatic cycle(input logic s, input logic [7:0] d, input logic r);
    rx_strb = s;
    rx_data = d;
    ready   = r;
    model_edge(s, d, r);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {7'd0, char_valid}, 8'h00);
    chk("rst_data", char_data, 8'h00);
    chk("rst_shift", {7'd0, shift_active}, 8'h00);
    chk("rst_ovf", {7'd0, fifo_overflow}, 8'h00);
    rst_n = 1'b1;

    // Single make code, then pop
    cycle(1'b1, 8'h1C, 1'b0);
    chk("t1_data", char_data, 8'h41);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t1_popped", {7'd0, char_valid}, 8'h00);

    // Break code produces nothing
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h1C, 1'b0);
    chk("t2_nopush", {7'd0, char_valid}, 8'h00);
    cycle(1'b1, 8'h32, 1'b0);
    chk("t2_data", char_data, 8'h42);
    cycle(1'b0, 8'h00, 1'b1);

    // Shift held/released around 4A
    cycle(1'b1, 8'h12, 1'b0);
    cycle(1'b1, 8'h4A, 1'b0);
    chk("t3_shift_on", {7'd0, shift_active}, 8'h01);
    cycle(1'b1, 8'hF0, 1'b0);
    cycle(1'b1, 8'h12, 1'b0);
    chk("t3_shift_off", {7'd0, shift_active}, 8'h00);
    cycle(1'b1, 8'h4A, 1'b0);
    chk("t3_first", char_data, 8'h3F);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t3_second", char_data, 8'h2F);
    cycle(1'b0, 8'h00, 1'b1);

    // Extended codes and ignored bytes
    cycle(1'b1, 8'hE0, 1'b0); cycle(1'b1, 8'h75, 1'b0);
    cycle(1'b1, 8'hE0, 1'b0); cycle(1'b1, 8'hF0, 1'b0); cycle(1'b1, 8'h75, 1'b0);
    chk("t4_none", {7'd0, char_valid}, 8'h00);
    cycle(1'b1, 8'hE0, 1'b0); cycle(1'b1, 8'h5A, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0); cycle(1'b1, 8'hFA, 1'b0);
    chk("t4_enter", char_data, 8'h0D);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t4_only_one", {7'd0, char_valid}, 8'h00);

    // Overflow on fifth push, drain, then full with simultaneous pop and push
    cycle(1'b1, 8'h16, 1'b0); cycle(1'b1, 8'h1E, 1'b0); cycle(1'b1, 8'h26, 1'b0);
    cycle(1'b1, 8'h25, 1'b0); cycle(1'b1, 8'h2E, 1'b0);
    chk("t5_ovf_pulse", {7'd0, fifo_overflow}, 8'h01);
    cycle(1'b0, 8'h00, 1'b0);
    chk("t5_ovf_once", {7'd0, fifo_overflow}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("t5_drain", char_data, 8'(8'h31 + i));
      cycle(1'b0, 8'h00, 1'b1);
    end
    cycle(1'b1, 8'h16, 1'b0); cycle(1'b1, 8'h1E, 1'b0); cycle(1'b1, 8'h26, 1'b0);
    cycle(1'b1, 8'h25, 1'b0);
    cycle(1'b1, 8'h2E, 1'b1);
    chk("t5_popush_noovf", {7'd0, fifo_overflow}, 8'h00);
    repeat (4) cycle(1'b0, 8'h00, 1'b1);

    // Async reset while in BREAK with data queued
    cycle(1'b1, 8'h12, 1'b0); cycle(1'b1, 8'h1C, 1'b0); cycle(1'b1, 8'h1C, 1'b0);
    cycle(1'b1, 8'hF0, 1'b0);
    rx_strb = 1'b0;
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_valid_drop", {7'd0, char_valid}, 8'h00);
    chk("t6_shift_drop", {7'd0, shift_active}, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(1'b1, 8'h1C, 1'b0);
    chk("t6_after", char_data, 8'h41);
    cycle(1'b0, 8'h00, 1'b1);

    // Random byte stream with varying downstream back-pressure
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 1)), pool[$urandom_range(0, 19)],
            (n < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    repeat (8) cycle(1'b0, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the received-byte stream of the PS/2 receiver (8-bit data plus one-cycle strobe) and interprets it as scan code set 2. It tracks the E0 (extended) and F0 (break) prefixes and the shift-key state, and translates make codes into 8-bit ASCII characters. Characters are queued in a small FIFO and handed downstream to the Morse encoder over a valid/ready handshake.

## Interface

Parameters:

- FIFO_DEPTH, default 4: number of character entries; power of two, ≥ 2.

Ports:

- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ps2_received_data  input  8  received byte; valid only in the strobe cycle.
- ps2_received_data_strb  input  1  one-cycle pulse; a new byte is available.
- char_ready  input  1  downstream accepts the head character this cycle.
- char_data  output  8  ASCII character at the FIFO head.
- char_valid  output  1  FIFO not empty.
- shift_active  output  1  left or right shift currently held.
- fifo_overflow  output  1  one-cycle pulse; a character was dropped because the FIFO was full.

## Operation

Decoder FSM states: IDLE, EXT, BREAK, EXT_BREAK. Bytes are processed only in strobe cycles.

IDLE:
- E0 → EXT.
- F0 → BREAK.
- AA, FA, EE, FE, 00, FF → ignored; stay in IDLE.
- 12 → set shift_l.
- 59 → set shift_r.
- Any other byte → look it up; if mapped, push the character; stay in IDLE.
- Typematic repeats push again.

EXT:
- F0 → EXT_BREAK.
- 5A → push 0x0D, then IDLE.
- Any other byte → discard, then IDLE.

BREAK:
- 12 clears shift_l; 59 clears shift_r.
- Any byte → no push, then IDLE.

EXT_BREAK:
- Any byte → discard, then IDLE.

shift_active = shift_l | shift_r.

Mapping (set 2 → ASCII). Letters are always uppercase, regardless of shift.
- Letters, A–Z in order: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
- Digits 0–9: 45 16 1E 26 25 2E 36 3D 3E 46.
- Controls: 29 → 0x20, 5A → 0x0D, 66 → 0x08.
- Punctuation: 49 → '.', 41 → ','.
- 4A → '/', or '?' when shift_active.
- Unmapped codes produce no push.

FIFO:
- Circular buffer with read/write pointers of width log2(FIFO_DEPTH) and an occupancy count of width log2(FIFO_DEPTH)+1.
- Pop when char_valid && char_ready.
- Push when not full, or when full with a pop in the same cycle.
- Full, with no pop, and a push request: the character is dropped and fifo_overflow pulses for one cycle.
- Simultaneous push and pop on an empty FIFO is impossible (char_valid = 0), so a push into an empty FIFO always lands.
- Pointers wrap modulo FIFO_DEPTH.

## Timing

- Reset (async, immediate on rst_n low):
  - FSM → IDLE; shift_l = shift_r = 0.
  - FIFO storage, pointers and count → 0.
  - char_valid = 0, char_data = 0x00, shift_active = 0, fifo_overflow = 0.
  - Any partially received prefix is lost.
- Latency: a strobe sampled at edge N writes the FIFO at edge N; char_valid and char_data reflect it in cycle N+1 when the FIFO was empty.
- FSM state and shift flags update at the edge that samples the strobe.
- shift_active is registered and takes effect for the next byte. This holds even if a shift code and a mapped code arrive in back-to-back strobe cycles.
- char_data is stable while char_valid = 1 and char_ready = 0.
- The head advances on the edge where char_valid && char_ready.
- Throughput: one push and one pop per cycle.
- Strobes arriving in consecutive cycles are each processed.
- fifo_overflow is asserted in the cycle after the dropped push's edge, for exactly one cycle.

## Test plan

- Strobe 0x1C with the FIFO empty and char_ready = 0 → char_valid rises the next cycle, char_data = 0x41. Raise char_ready for one cycle → char_valid = 0.
- Strobe F0 then 1C → no push; FSM back in IDLE. A following 0x32 → char_data = 0x42.
- Strobe 12, 4A, F0, 12, 4A → shift_active goes 1 then 0; FIFO holds 0x3F then 0x2F, popped in that order.
- Strobe E0 75, E0 F0 75, then E0 5A → only 0x0D is queued. Also strobe AA and FA → nothing queued.
- FIFO_DEPTH = 4, char_ready = 0, strobe 16 1E 26 25 2E → first four queued, fifo_overflow pulses once on the fifth. Drain yields 0x31 0x32 0x33 0x34. Then full plus a simultaneous pop and push → push accepted, no overflow.
- With 2 entries queued and the FSM in BREAK, pull rst_n low mid-cycle → char_valid and shift_active drop immediately. After release, strobe 1C → 0x41 is queued (the break state was cleared).
